// File: rtl/ita_pkg.sv
// Shared constants, types and receiver state encoding for the host UART loader.
package ita_pkg;

    localparam int DATA_BITS         = 8;
    localparam int ACT_BITS          = 8;
    localparam int DEFAULT_CLK_FREQ  = 125_000_000;
    localparam int DEFAULT_BAUD_RATE = 115200;

    typedef logic [ACT_BITS-1:0] act_t;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_IDLE
    } uart_rx_state_e;

endpackage

// File: rtl/uart_vec_rx_core.sv
// 8N1 byte receiver: input synchroniser, baud counter and framing FSM.
module uart_rx_core
    import ita_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1085,
    parameter int HALF_BIT     = 542
) (
    input  logic clk,
    input  logic rst,
    input  logic uart_rx,
    output act_t rx_data,
    output logic rx_strobe,
    output logic frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);

    logic [1:0]       sync_q;
    logic             rx_s;
    uart_rx_state_e   state;
    uart_rx_state_e   state_next;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    act_t             shift_q;
    logic             tick;

    // Sync loads idle-high so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (rst) sync_q <= 2'b11;
        else     sync_q <= {sync_q[0], uart_rx};
    end

    assign rx_s    = sync_q[1];
    assign rx_data = shift_q;

    always_comb begin
        if (state == RX_START) tick = (baud_cnt == CNT_W'(HALF_BIT - 1));
        else                   tick = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= RX_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            RX_IDLE:      if (!rx_s) state_next = RX_START;
            RX_START:     if (tick) state_next = rx_s ? RX_IDLE : RX_DATA;
            RX_DATA:      if (tick && bit_cnt == 3'(DATA_BITS - 1)) state_next = RX_STOP;
            RX_STOP:      if (tick) state_next = rx_s ? RX_IDLE : RX_WAIT_IDLE;
            RX_WAIT_IDLE: if (rx_s) state_next = RX_IDLE;
            default:      state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_strobe = 1'b0;
        frame_err = 1'b0;
        if (state == RX_STOP && tick) begin
            rx_strobe = rx_s;
            frame_err = !rx_s;
        end
    end

    // Bits arrive LSB first, so shift right and insert at the MSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            if (state == RX_IDLE || state == RX_WAIT_IDLE || tick) baud_cnt <= '0;
            else                                                    baud_cnt <= baud_cnt + 1'b1;
            if (state == RX_START) bit_cnt <= '0;
            if (state == RX_DATA && tick) begin
                shift_q <= {rx_s, shift_q[ACT_BITS-1:1]};
                bit_cnt <= bit_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_vec_rx.sv
// Packs VEC_LEN received UART bytes into one activation vector with valid/ready output.
module uart_vec_rx
    import ita_pkg::*;
#(
    parameter int CLK_FREQ       = DEFAULT_CLK_FREQ,
    parameter int BAUD_RATE      = DEFAULT_BAUD_RATE,
    parameter int VEC_LEN        = 64,
    parameter int ACT_BITS       = 8,
    parameter int TIMEOUT_CYCLES = 16 * (CLK_FREQ / BAUD_RATE) * 10
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             uart_rx,
    output logic [VEC_LEN-1:0][ACT_BITS-1:0] vec_out,
    output logic                             vec_valid,
    input  logic                             vec_ready,
    output logic [$clog2(VEC_LEN)-1:0]       byte_idx,
    output logic                             frame_err,
    output logic                             overrun_err,
    output logic                             timeout_err
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int IDX_W        = $clog2(VEC_LEN);
    localparam int TO_W         = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_LEN - 1);

    if (ACT_BITS != 8) begin : g_bad_act_bits
        $error("uart_vec_rx: ACT_BITS must be 8");
    end

    act_t            rx_byte;
    logic            rx_strobe;
    logic [TO_W-1:0] gap_cnt;

    uart_rx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .HALF_BIT    (HALF_BIT)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .uart_rx  (uart_rx),
        .rx_data  (rx_byte),
        .rx_strobe(rx_strobe),
        .frame_err(frame_err)
    );

    // A strobe during vec_valid (even the accepting cycle) is an overrun;
    // a strobe always beats a simultaneous timeout.
    always_ff @(posedge clk) begin
        if (rst) begin
            vec_out     <= '0;
            vec_valid   <= 1'b0;
            byte_idx    <= '0;
            gap_cnt     <= '0;
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            timeout_err <= 1'b0;
            if (vec_valid && vec_ready) vec_valid <= 1'b0;

            if (rx_strobe) begin
                gap_cnt <= '0;
                if (vec_valid) begin
                    overrun_err <= 1'b1;
                end else begin
                    vec_out[byte_idx] <= rx_byte;
                    if (byte_idx == LAST_IDX) begin
                        byte_idx  <= '0;
                        vec_valid <= 1'b1;
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
            end else if (byte_idx == '0) begin
                gap_cnt <= '0;
            end else if (!vec_valid) begin
                if (gap_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    gap_cnt     <= '0;
                    byte_idx    <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_vec_rx.sv
// Directed scoreboard bench for uart_vec_rx at 10 clocks per bit, 4-byte vectors.
module tb_uart_vec_rx;

    localparam int CLK_FREQ = 1_000_000;
    localparam int BAUD     = 100_000;
    localparam int BIT      = 10;
    localparam int VEC_LEN  = 4;
    localparam int TO       = 200;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            uart_rx = 1'b1;
    logic            vec_ready = 1'b0;
    logic [3:0][7:0] vec_out;
    logic            vec_valid;
    logic [1:0]      byte_idx;
    logic            frame_err;
    logic            overrun_err;
    logic            timeout_err;

    int checks_total = 0;
    int checks_passed = 0;
    int frame_seen = 0;
    int overrun_seen = 0;
    int timeout_seen = 0;
    int valid_cycles = 0;
    logic [31:0] exp_q[$];
    logic [31:0] prev_out = '0;
    logic        prev_valid = 1'b0;

    always #5 clk = ~clk;

    uart_vec_rx #(
        .CLK_FREQ      (CLK_FREQ),
        .BAUD_RATE     (BAUD),
        .VEC_LEN       (VEC_LEN),
        .ACT_BITS      (8),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .uart_rx    (uart_rx),
        .vec_out    (vec_out),
        .vec_valid  (vec_valid),
        .vec_ready  (vec_ready),
        .byte_idx   (byte_idx),
        .frame_err  (frame_err),
        .overrun_err(overrun_err),
        .timeout_err(timeout_err)
    );

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks_total++;
        if (got === want) checks_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    // Monitor: inputs change just after posedge, so negedge sees the handshake the next edge will use.
    always @(negedge clk) begin
        if (!rst) begin
            if (frame_err)   frame_seen++;
            if (overrun_err) overrun_seen++;
            if (timeout_err) timeout_seen++;
            if (vec_valid)   valid_cycles++;
            if (prev_valid && vec_valid) check_output("hold_stable", vec_out, prev_out);
            if (vec_valid && vec_ready) begin
                if (exp_q.size() == 0) begin
                    checks_total++;
                    $display("[TB] FAIL unexpected_vector: got 0x%0h, expected none", vec_out);
                end else begin
                    check_output("vector", vec_out, exp_q.pop_front());
                end
            end
        end
        prev_valid = vec_valid && !rst;
        prev_out   = vec_out;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low);
        uart_rx = 1'b0;
        step(BIT);
        for (int i = 0; i < 8; i++) begin
            uart_rx = d[i];
            step(BIT);
        end
        uart_rx = stop;
        step(BIT + extra_low);
        uart_rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_frame(d, 1'b1, 0);
    endtask

    task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2, input logic [7:0] b3);
        exp_q.push_back({b3, b2, b1, b0});
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            step(1);
            n++;
        end
        check_output({name, "_drain"}, exp_q.size(), 0);
    endtask

    int v0, f0, o0, t0;

    initial begin
        $display("[TB] start");
        step(3);
        rst = 1'b0;
        step(1);
        check_output("reset_valid", vec_valid, 0);
        check_output("reset_idx", byte_idx, 0);
        check_output("reset_vec", vec_out, 0);
        check_output("reset_errs", {frame_err, overrun_err, timeout_err}, 0);

        // Basic back-to-back vector with ready held high
        vec_ready = 1'b1;
        v0 = valid_cycles;
        apply_stimulus(8'h11, 8'h22, 8'h33, 8'h44);
        wait_drain("basic");
        step(2);
        check_output("basic_valid_len", valid_cycles - v0, 1);
        check_output("basic_idx", byte_idx, 0);
        check_output("basic_errs", frame_seen + overrun_seen + timeout_seen, 0);

        // Backpressure and overrun
        step(20);
        vec_ready = 1'b0;
        apply_stimulus(8'hA0, 8'hA1, 8'hA2, 8'hA3);
        send_byte(8'h55);
        step(5);
        check_output("overrun_count", overrun_seen, 1);
        check_output("bp_valid", vec_valid, 1);
        check_output("bp_vec", vec_out, 32'hA3A2A1A0);
        check_output("bp_idx", byte_idx, 0);
        vec_ready = 1'b1;
        step(1);
        check_output("bp_valid_drop", vec_valid, 0);
        wait_drain("bp");
        apply_stimulus(8'hB0, 8'hB1, 8'hB2, 8'hB3);
        wait_drain("bp_next");

        // Framing error, then clean reception
        step(20);
        f0 = frame_seen;
        send_frame(8'h3C, 1'b0, 30);
        step(5);
        check_output("frame_count", frame_seen - f0, 1);
        check_output("frame_idx", byte_idx, 0);
        step(20);
        exp_q.push_back(32'h04030201);
        send_byte(8'h01);
        check_output("frame_recover_idx", byte_idx, 1);
        send_byte(8'h02);
        send_byte(8'h03);
        send_byte(8'h04);
        wait_drain("frame");

        // Short glitch must be rejected silently
        step(20);
        f0 = frame_seen; o0 = overrun_seen; t0 = timeout_seen; v0 = valid_cycles;
        uart_rx = 1'b0;
        step(3);
        uart_rx = 1'b1;
        step(30);
        check_output("glitch_errs", (frame_seen - f0) + (overrun_seen - o0) + (timeout_seen - t0), 0);
        check_output("glitch_idx", byte_idx, 0);
        check_output("glitch_valid", valid_cycles - v0, 0);

        // Timeout of a partial vector
        t0 = timeout_seen;
        send_byte(8'hC1);
        send_byte(8'hC2);
        check_output("to_partial_idx", byte_idx, 2);
        step(150);
        check_output("to_early_count", timeout_seen - t0, 0);
        check_output("to_early_idx", byte_idx, 2);
        step(100);
        check_output("to_count", timeout_seen - t0, 1);
        check_output("to_idx", byte_idx, 0);
        apply_stimulus(8'hD0, 8'hD1, 8'hD2, 8'hD3);
        wait_drain("to");

        // Reset in the middle of a vector
        step(20);
        send_byte(8'hE0);
        send_byte(8'hE1);
        send_byte(8'hE2);
        check_output("rst_pre_idx", byte_idx, 3);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        check_output("rst_idx", byte_idx, 0);
        check_output("rst_vec", vec_out, 0);
        check_output("rst_valid", vec_valid, 0);
        step(5);
        apply_stimulus(8'hF0, 8'hF1, 8'hF2, 8'hF3);
        wait_drain("rst");
        step(20);
        check_output("total_frame", frame_seen, 1);
        check_output("total_overrun", overrun_seen, 1);
        check_output("total_timeout", timeout_seen, 1);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
